mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- N-port memory arbiter: multiplexes NUM_PORTS requesters (instruction fetch, data load/store, future DMA/debug) onto one shared RAM port.
- Generalised successor of the fixed two-channel I/D memory controller.
- Adds configurable port count, fixed-priority or round-robin arbitration, latched requests, per-port read-data holding, and a busy-timeout watchdog with per-port error reporting.
- Sits between the core's memory-side interfaces and the RAM/bus wrapper.

Parameters:
- NUM_PORTS, 2, number of requesters; range 2..8; port 0 is highest fixed priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 255, max cycles ram_busy may stay high in ACCESS before abort; 0 disables the watchdog.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- req_ren  in  NUM_PORTS  per-port read request, level, held until port_ready/port_err.
- req_wen  in  NUM_PORTS  per-port write request, level, held until port_ready/port_err.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  per-port store data.
- port_rdata  out  NUM_PORTS*DATA_W  per-port last read data, registered.
- port_ready  out  NUM_PORTS  one-cycle completion pulse.
- port_err  out  NUM_PORTS  one-cycle timeout-abort pulse.
- grant_id  out  $clog2(NUM_PORTS)  index of the port currently granted.
- arb_busy  out  1  high while in ACCESS.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM store data.
- ram_rdata  in  DATA_W  RAM load data, valid when ram_busy is low.
- ram_busy  in  1  RAM stall; access completes on the first ACCESS cycle with ram_busy low.

Behaviour:
- Reset (RST high at a clock edge, from any state): state IDLE; all outputs 0; port_rdata 0; RR pointer 0; timeout counter 0. An in-flight access is abandoned with no ready/err pulse.
- Pending vector: pend[i] = req_ren[i] | req_wen[i].
- IDLE:
  - If pend is nonzero, select winner W.
    - RR_MODE=0: lowest set index.
    - RR_MODE=1: first set index at or after the pointer, wrapping modulo NUM_PORTS.
  - Latch W's addr, wdata and op. Write takes precedence when ren and wen are both set.
  - grant_id <= W; go to ACCESS.
  - RAM strobes are low in IDLE.
- ACCESS:
  - ram_ren/ram_wen/ram_addr/ram_wdata are driven from the latched registers. Exactly one strobe is high.
  - arb_busy = 1.
  - If ram_busy = 0 this cycle:
    - For reads, port_rdata[W] <= ram_rdata.
    - port_ready[W] pulses in the next cycle.
    - RR pointer <= (W+1) mod NUM_PORTS.
    - Return to IDLE.
  - Else the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT:
    - Abort: strobes drop; port_err[W] pulses next cycle.
    - The pointer advances as on completion; port_rdata[W] is unchanged.
    - Return to IDLE.
  - The counter clears on entering ACCESS.
- Latency: minimum 3 cycles from request assertion to port_ready (grant edge, access cycle, ready pulse), plus one cycle per ram_busy-high cycle. Back-to-back grants have one IDLE cycle between accesses.
- Requester changes addr/data or drops its request during ACCESS: ignored, since the latched values are used. The access completes and the pulse still fires.
- A new request arriving during ACCESS waits; it is never preempted into the current access.
- port_ready and port_err are never both high, and at most one bit of either is set per cycle.
- port_rdata for non-granted ports holds its value indefinitely.
- NUM_PORTS not a power of two: the pointer wraps at NUM_PORTS-1 to 0 and never holds an invalid index.

Test Plan:
- Reset: hold RST 2 cycles mid-ACCESS (port 1 write, ram_busy=1) -> next cycle all outputs 0, state IDLE, no port_ready/port_err pulse.
- Single read: port 0 ren, addr 0x100; ram_busy high 3 cycles, then low with ram_rdata 0xDEADBEEF -> ram_ren high 4 cycles; port_ready[0] pulses at cycle 6; port_rdata[0] = 0xDEADBEEF.
- Fixed priority, RR_MODE=0, ports 0/1 requesting continuously, ram_busy=0 -> grants 0,0,0,...; port 1 starved.
- Round-robin, NUM_PORTS=3, all requesting, ram_busy=0 -> grant_id sequence 0,1,2,0,1,2; each port_ready pulses once per 3 grants.
- Ren+wen on port 1 with wdata 0x12345678 -> ram_wen=1, ram_ren=0, ram_wdata 0x12345678; port_rdata[1] unchanged.
- Timeout, TIMEOUT=4, port 0 read, ram_busy stuck high -> strobe drops after 4 ACCESS cycles; port_err[0] pulses once; port_ready stays 0; next pending port is granted.

Source files
------------

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: requester-side and RAM-side bundle
// for the N-port memory arbiter.
interface mem_arbiter_rr_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int GW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]        req_ren;
  logic [NUM_PORTS-1:0]        req_wen;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS*DATA_W-1:0] port_rdata;
  logic [NUM_PORTS-1:0]        port_ready;
  logic [NUM_PORTS-1:0]        port_err;
  logic [GW-1:0]               grant_id;
  logic                        arb_busy;
  logic                        ram_ren;
  logic                        ram_wen;
  logic [ADDR_W-1:0]           ram_addr;
  logic [DATA_W-1:0]           ram_wdata;
  logic [DATA_W-1:0]           ram_rdata;
  logic                        ram_busy;

  modport slave (
    input  req_ren, req_wen, req_addr, req_wdata,
    input  ram_rdata, ram_busy,
    output port_rdata, port_ready, port_err,
    output grant_id, arb_busy,
    output ram_ren, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output req_ren, req_wen, req_addr, req_wdata,
    output ram_rdata, ram_busy,
    input  port_rdata, port_ready, port_err,
    input  grant_id, arb_busy,
    input  ram_ren, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port fixed/round-robin arbiter onto
// one shared RAM port, with busy-timeout watchdog.
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_MODE   = 1,
  parameter int TIMEOUT   = 255
) (
  input logic            CLK,
  input logic            RST,
  mem_arbiter_rr_if.slave bus
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);
  localparam logic [GW-1:0] LAST = GW'(NUM_PORTS - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e state_q, state_d;

  logic [NUM_PORTS-1:0] pend;
  logic [GW-1:0]        win;
  logic                 acc;
  logic                 done;
  logic                 tout;

  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gnt_nx;

  logic              op_w_q, op_w_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_nx;

  logic [NUM_PORTS*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]        rdy_q, rdy_d;
  logic [NUM_PORTS-1:0]        err_q, err_d;

  assign pend   = bus.req_ren | bus.req_wen;
  assign acc    = (state_q == S_ACCESS);
  assign cnt_nx = cnt_q + 1'b1;
  assign done   = acc && !bus.ram_busy;
  assign tout   = acc && bus.ram_busy && TO_EN
                  && (cnt_nx == TO_V);
  assign gnt_nx = (gnt_q == LAST) ? '0 : gnt_q + 1'b1;

  // Winner: first pending port scanning upward from the
  // RR pointer (or from 0 in fixed mode), wrapping.
  always_comb begin
    int s;
    logic [GW-1:0] idx;
    s   = 0;
    idx = '0;
    win = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (RR_MODE != 0) begin
        s = int'(ptr_q) + k;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
      end else begin
        s = k;
      end
      idx = GW'(s);
      if (pend[idx]) win = idx;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: grant on any pending, leave on done/abort.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (|pend) state_d = S_ACCESS;
      S_ACCESS: if (done || tout) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // RAM-side outputs come from the latched request only.
  always_comb begin
    bus.arb_busy  = acc;
    bus.ram_ren   = acc && !op_w_q;
    bus.ram_wen   = acc && op_w_q;
    bus.ram_addr  = acc ? addr_q : '0;
    bus.ram_wdata = acc ? wdata_q : '0;
  end

  assign bus.grant_id   = gnt_q;
  assign bus.port_rdata = rdata_q;
  assign bus.port_ready = rdy_q;
  assign bus.port_err   = err_q;

  // Request latch, completion, watchdog and pointer update.
  always_comb begin
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    op_w_d  = op_w_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rdy_d   = '0;
    err_d   = '0;
    if (!acc && |pend) begin
      gnt_d   = win;
      op_w_d  = bus.req_wen[win];
      addr_d  = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
      wdata_d = bus.req_wdata[int'(win)*DATA_W +: DATA_W];
      cnt_d   = '0;
    end
    if (done) begin
      if (!op_w_q)
        rdata_d[int'(gnt_q)*DATA_W +: DATA_W] = bus.ram_rdata;
      rdy_d[gnt_q] = 1'b1;
      ptr_d        = gnt_nx;
    end else if (tout) begin
      err_d[gnt_q] = 1'b1;
      ptr_d        = gnt_nx;
    end else if (acc && TO_EN) begin
      cnt_d = cnt_nx;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_q   <= '0;
      ptr_q   <= '0;
      op_w_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rdy_q   <= '0;
      err_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      op_w_q  <= op_w_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: vectors, corner sequences and random
// traffic against a transaction-level reference.
module tb_mem_arbiter_rr;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.NUM_PORTS(NP), .ADDR_W(AW),
                      .DATA_W(DW)) bus ();
  mem_arbiter_rr_if #(.NUM_PORTS(2), .ADDR_W(AW),
                      .DATA_W(DW)) fbus ();

  mem_arbiter_rr #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
    .RR_MODE(1), .TIMEOUT(TO)
  ) u_rr (
    .CLK(clk), .RST(rst), .bus(bus.slave)
  );

  mem_arbiter_rr #(
    .NUM_PORTS(2), .ADDR_W(AW), .DATA_W(DW),
    .RR_MODE(0), .TIMEOUT(255)
  ) u_fp (
    .CLK(clk), .RST(rst), .bus(fbus.slave)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // Reference: one outstanding transaction at most; a grant
  // picks the first requester at/after the pointer.
  int          m_cur = -1;
  int          m_ptr = 0;
  int          m_wt  = 0;
  int          m_gnt = 0;
  bit          m_w   = 1'b0;
  logic [31:0] m_a   = '0;
  logic [31:0] m_d   = '0;
  logic [31:0] m_rd [NP] = '{default: '0};
  logic [NP-1:0] m_rdy = '0;
  logic [NP-1:0] m_er  = '0;

  always @(posedge clk) begin : model
    logic [NP-1:0] pend;
    int w;
    m_rdy = '0;
    m_er  = '0;
    pend  = bus.req_ren | bus.req_wen;
    w     = -1;
    if (rst) begin
      m_cur = -1;
      m_ptr = 0;
      m_wt  = 0;
      m_gnt = 0;
      for (int i = 0; i < NP; i++) m_rd[i] = '0;
    end else if (m_cur < 0) begin
      for (int k = 0; k < NP; k++)
        if (w < 0 && pend[(m_ptr + k) % NP])
          w = (m_ptr + k) % NP;
      if (w >= 0) begin
        m_cur = w;
        m_gnt = w;
        m_w   = bus.req_wen[w];
        m_a   = bus.req_addr[w*AW +: AW];
        m_d   = bus.req_wdata[w*DW +: DW];
        m_wt  = 0;
      end
    end else if (!bus.ram_busy) begin
      if (!m_w) m_rd[m_cur] = bus.ram_rdata;
      m_rdy[m_cur] = 1'b1;
      m_ptr = (m_cur + 1) % NP;
      m_cur = -1;
    end else begin
      m_wt++;
      if (m_wt == TO) begin
        m_er[m_cur] = 1'b1;
        m_ptr = (m_cur + 1) % NP;
        m_cur = -1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    bit act;
    act = (m_cur >= 0);
    chk("mon_busy", 64'(bus.arb_busy), 64'(act));
    chk("mon_ren", 64'(bus.ram_ren), 64'(act && !m_w));
    chk("mon_wen", 64'(bus.ram_wen), 64'(act && m_w));
    chk("mon_addr", 64'(bus.ram_addr),
        act ? 64'(m_a) : 64'd0);
    chk("mon_wdata", 64'(bus.ram_wdata),
        act ? 64'(m_d) : 64'd0);
    chk("mon_grant", 64'(bus.grant_id), 64'(m_gnt));
    chk("mon_ready", 64'(bus.port_ready), 64'(m_rdy));
    chk("mon_err", 64'(bus.port_err), 64'(m_er));
    for (int i = 0; i < NP; i++)
      chk("mon_rdata", 64'(bus.port_rdata[i*DW +: DW]),
          64'(m_rd[i]));
  end

  typedef struct {
    int          port;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nbusy;
    logic [31:0] rdata;
    int          exp_lat;
    bit          exp_err;
    bit          exp_w;
    int          exp_strb;
    logic [31:0] exp_prd;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int c, rc, wc;
    bit gr, ge;
    logic [31:0] ad, wd;
    rc = 0; wc = 0; gr = 0; ge = 0; ad = '0; wd = '0;
    tick();
    c = 1;
    bus.req_ren[v.port] = v.ren;
    bus.req_wen[v.port] = v.wen;
    bus.req_addr[v.port*AW +: AW]  = v.addr;
    bus.req_wdata[v.port*DW +: DW] = v.wdata;
    bus.ram_rdata = v.rdata;
    bus.ram_busy  = (c <= v.nbusy + 1);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      rc += int'(bus.ram_ren);
      wc += int'(bus.ram_wen);
      if (bus.ram_ren || bus.ram_wen) begin
        ad = bus.ram_addr;
        wd = bus.ram_wdata;
      end
      if (bus.port_ready[v.port] || bus.port_err[v.port]) begin
        gr = bus.port_ready[v.port];
        ge = bus.port_err[v.port];
        break;
      end
      tick();
      c++;
      bus.ram_busy = (c <= v.nbusy + 1);
    end
    bus.req_ren[v.port] = 1'b0;
    bus.req_wen[v.port] = 1'b0;
    bus.ram_busy = 1'b0;
    chk($sformatf("vec%0d_done", id), 64'(gr | ge), 64'd1);
    chk($sformatf("vec%0d_err", id), 64'(ge), 64'(v.exp_err));
    chk($sformatf("vec%0d_ready", id), 64'(gr),
        64'(!v.exp_err));
    chk($sformatf("vec%0d_lat", id), 64'(c), 64'(v.exp_lat));
    chk($sformatf("vec%0d_strb", id),
        64'(v.exp_w ? wc : rc), 64'(v.exp_strb));
    chk($sformatf("vec%0d_other", id),
        64'(v.exp_w ? rc : wc), 64'd0);
    chk($sformatf("vec%0d_addr", id), 64'(ad), 64'(v.addr));
    if (v.exp_w)
      chk($sformatf("vec%0d_wdata", id), 64'(wd),
          64'(v.wdata));
    chk($sformatf("vec%0d_prd", id),
        64'(bus.port_rdata[v.port*DW +: DW]),
        64'(v.exp_prd));
  endtask

  initial begin
    int exp_g [6];
    int g, rcnt0, rcnt1, rcnt2, r1, npulse, stuck;
    bit saw1, ok;

    bus.req_ren   = '0;
    bus.req_wen   = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.ram_rdata = '0;
    bus.ram_busy  = 1'b0;
    fbus.req_ren   = '0;
    fbus.req_wen   = '0;
    fbus.req_addr  = '0;
    fbus.req_wdata = '0;
    fbus.ram_rdata = '0;
    fbus.ram_busy  = 1'b0;

    vt[0] = '{0, 1'b1, 1'b0, 32'h100, 32'h0, 3,
              32'hDEADBEEF, 6, 1'b0, 1'b0, 4, 32'hDEADBEEF};
    vt[1] = '{1, 1'b1, 1'b1, 32'h140, 32'h12345678, 0,
              32'hAAAA5555, 3, 1'b0, 1'b1, 1, 32'h0};
    vt[2] = '{2, 1'b1, 1'b0, 32'h200, 32'h0, 1,
              32'hCAFEF00D, 4, 1'b0, 1'b0, 2, 32'hCAFEF00D};
    vt[3] = '{1, 1'b1, 1'b0, 32'h144, 32'h0, 0,
              32'h11112222, 3, 1'b0, 1'b0, 1, 32'h11112222};
    vt[4] = '{1, 1'b0, 1'b1, 32'h148, 32'h99, 2,
              32'h55555555, 5, 1'b0, 1'b1, 3, 32'h11112222};
    vt[5] = '{0, 1'b1, 1'b0, 32'h104, 32'h0, 3,
              32'h0BADF00D, 6, 1'b0, 1'b0, 4, 32'h0BADF00D};
    vt[6] = '{0, 1'b1, 1'b0, 32'h108, 32'h0, 4,
              32'h77777777, 6, 1'b1, 1'b0, 4, 32'h0BADF00D};
    vt[7] = '{2, 1'b0, 1'b1, 32'h204, 32'hFEEDFACE, 20,
              32'h0, 6, 1'b1, 1'b1, 4, 32'hCAFEF00D};

    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.arb_busy), 64'd0);
    chk("rst_grant", 64'(bus.grant_id), 64'd0);
    chk("rst_rdata", 64'(|bus.port_rdata), 64'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

    // Round-robin: all three held, RAM never stalls.
    exp_g = '{0, 1, 2, 0, 1, 2};
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_ren = '1;
    g = 0; rcnt0 = 0; rcnt1 = 0; rcnt2 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      rcnt0 += int'(bus.port_ready[0]);
      rcnt1 += int'(bus.port_ready[1]);
      rcnt2 += int'(bus.port_ready[2]);
      if (g == 6) break;
      if (bus.arb_busy) begin
        chk($sformatf("rr_grant%0d", g),
            64'(bus.grant_id), 64'(exp_g[g]));
        g++;
      end
    end
    bus.req_ren = '0;
    chk("rr_count", 64'(g), 64'd6);
    chk("rr_rdy0", 64'(rcnt0), 64'd2);
    chk("rr_rdy1", 64'(rcnt1), 64'd2);
    chk("rr_rdy2", 64'(rcnt2), 64'd2);

    // Reset while port 1 write is stalled in ACCESS.
    tick();
    bus.req_wen[1] = 1'b1;
    bus.req_addr[1*AW +: AW] = 32'h300;
    bus.ram_busy = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("rsta_busy", 64'(bus.arb_busy), 64'd1);
    rst = 1'b1;
    bus.req_wen = '0;
    tick();
    tick();
    rst = 1'b0;
    bus.ram_busy = 1'b0;
    @(negedge clk);
    chk("rsta_arb", 64'(bus.arb_busy), 64'd0);
    chk("rsta_ren", 64'(bus.ram_ren), 64'd0);
    chk("rsta_wen", 64'(bus.ram_wen), 64'd0);
    chk("rsta_addr", 64'(bus.ram_addr), 64'd0);
    chk("rsta_grant", 64'(bus.grant_id), 64'd0);
    chk("rsta_rdata", 64'(|bus.port_rdata), 64'd0);
    for (int c = 0; c < 3; c++) begin
      chk("rsta_pulse",
          64'(|(bus.port_ready | bus.port_err)), 64'd0);
      @(negedge clk);
    end

    // Fixed priority: port 1 starves behind port 0.
    tick();
    fbus.req_ren = 2'b11;
    g = 0; r1 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      r1 += int'(fbus.port_ready[1]);
      if (fbus.arb_busy) begin
        chk("fp_grant", 64'(fbus.grant_id), 64'd0);
        g++;
        if (g == 4) break;
      end
    end
    fbus.req_ren = '0;
    chk("fp_count", 64'(g), 64'd4);
    chk("fp_starve", 64'(r1), 64'd0);
    tick();
    fbus.req_ren = 2'b10;
    saw1 = 0; ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fbus.arb_busy && fbus.grant_id == 1'b1) saw1 = 1;
      if (fbus.port_ready[1]) begin
        ok = 1;
        break;
      end
    end
    fbus.req_ren = '0;
    chk("fp_solo_grant", 64'(saw1), 64'd1);
    chk("fp_solo_ready", 64'(ok), 64'd1);

    // Random traffic, checked cycle by cycle by the monitor.
    npulse = 0;
    stuck  = 0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int p = 0; p < NP; p++) begin
        if (bus.req_ren[p] || bus.req_wen[p]) begin
          if (bus.port_ready[p] || bus.port_err[p]) begin
            bus.req_ren[p] = 1'b0;
            bus.req_wen[p] = 1'b0;
            npulse++;
          end else if ($urandom_range(0, 7) == 0) begin
            bus.req_addr[p*AW +: AW]  = $urandom();
            bus.req_wdata[p*DW +: DW] = $urandom();
          end
        end else if ($urandom_range(0, 3) == 0) begin
          bus.req_ren[p] = 1'($urandom_range(0, 1));
          bus.req_wen[p] = ~bus.req_ren[p]
                           | 1'($urandom_range(0, 1));
          bus.req_addr[p*AW +: AW]  = $urandom();
          bus.req_wdata[p*DW +: DW] = $urandom();
        end
      end
      if (stuck > 0) begin
        bus.ram_busy = 1'b1;
        stuck--;
      end else if ($urandom_range(0, 39) == 0) begin
        stuck = 6;
        bus.ram_busy = 1'b1;
      end else begin
        bus.ram_busy = ($urandom_range(0, 9) < 3);
      end
      bus.ram_rdata = $urandom();
    end
    chk("rand_progress", 64'(npulse > 100), 64'd1);
    bus.req_ren  = '0;
    bus.req_wen  = '0;
    bus.ram_busy = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end
endmodule
